// File: rtl/instq_mw_if.sv
// Fetch/decode-side bundle for the multi-lane instruction queue, plus the shared entry type.
// The slave modport is the queue's view; the master modport is the fetch/decode side.
package instq_mw_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] out_inst;
        logic        prediction;
    } if_id_stage_reg_t;

    localparam logic [6:0] OP_B_BR = 7'b1100011;
endpackage

interface instq_mw_if #(
    parameter int DEPTH = 8,
    parameter int ENQ_W = 2,
    parameter int DEQ_W = 2
);
    import instq_mw_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic                         flush;
    logic [ENQ_W-1:0]             enq_valid;
    if_id_stage_reg_t [ENQ_W-1:0] enq_entry;
    logic [ENQ_W-1:0]             enq_pred;
    logic                         enq_ready;
    logic [ENQ_W-1:0]             br_is_br;
    logic [ENQ_W-1:0][31:0]       br_pc;
    logic [ENQ_W-1:0][31:0]       br_target;
    logic [DEQ_W-1:0]             deq_valid;
    if_id_stage_reg_t [DEQ_W-1:0] deq_entry;
    logic [DEQ_W-1:0]             deq_ready;
    logic [CW-1:0]                count;
    logic                         empty;
    logic                         full;

    modport slave (
        input  flush, enq_valid, enq_entry, enq_pred, deq_ready,
        output enq_ready, br_is_br, br_pc, br_target,
               deq_valid, deq_entry, count, empty, full
    );

    modport master (
        output flush, enq_valid, enq_entry, enq_pred, deq_ready,
        input  enq_ready, br_is_br, br_pc, br_target,
               deq_valid, deq_entry, count, empty, full
    );
endinterface

// File: rtl/instq_mw.sv
// Multi-lane circular instruction queue, ENQ_W in / DEQ_W show-ahead out, flush on redirect.
// Latency 1 cycle enqueue-to-dequeue; 0 cycles on an empty queue when INSTQ_BYPASS_EN is defined.
// Backpressure: enq_ready credits only the free slots at the current count; deq_ready prefix pops lanes.
module instq_mw
    import instq_mw_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ENQ_W = 2,
    parameter int DEQ_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    instq_mw_if.slave   q
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if_id_stage_reg_t mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic                         enq_rdy;
    int                           n_enq, n_deq;
    logic [DEQ_W-1:0]             deq_vld;
    if_id_stage_reg_t [DEQ_W-1:0] deq_dat;
    logic [ENQ_W-1:0]             wr_en;
    logic [ENQ_W-1:0][PW-1:0]     wr_slot;
    if_id_stage_reg_t [ENQ_W-1:0] wr_dat;

    // Explicit wrap compare so non-power-of-two depths stay inside the buffer.
    function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] p, int k);
        int s;
        s = int'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return s[PW-1:0];
    endfunction

    function automatic logic is_prefix(logic [3:0] v);
        return (v & (v + 4'd1)) == 4'd0;
    endfunction

    assign enq_rdy     = (count_q <= CW'(DEPTH - ENQ_W));
    assign q.enq_ready = enq_rdy;
    assign q.count     = count_q;
    assign q.empty     = (count_q == '0);
    assign q.full      = (count_q == CW'(DEPTH));
    assign q.deq_valid = deq_vld;
    assign q.deq_entry = deq_dat;

    always_comb begin
        for (int k = 0; k < ENQ_W; k++) begin
            wr_dat[k]            = q.enq_entry[k];
            wr_dat[k].prediction = q.enq_pred[k];
        end
    end

    for (genvar k = 0; k < ENQ_W; k++) begin : g_br
        logic [31:0] imm;
        assign imm = {{20{q.enq_entry[k].out_inst[31]}}, q.enq_entry[k].out_inst[7],
                      q.enq_entry[k].out_inst[30:25], q.enq_entry[k].out_inst[11:8], 1'b0};
        assign q.br_is_br[k]  = (q.enq_entry[k].out_inst[6:0] == OP_B_BR);
        assign q.br_pc[k]     = q.br_is_br[k] ? q.enq_entry[k].pc : 32'd0;
        assign q.br_target[k] = q.br_is_br[k] ? (q.enq_entry[k].pc + imm) : 32'd0;
    end

`ifdef INSTQ_BYPASS_EN
    localparam int BW = (ENQ_W > DEQ_W) ? ENQ_W : DEQ_W;
    logic [BW-1:0]             byp_vld;
    if_id_stage_reg_t [BW-1:0] byp_dat;

    for (genvar k = 0; k < ENQ_W; k++) begin : g_byp
        assign byp_vld[k] = q.enq_valid[k];
        assign byp_dat[k] = wr_dat[k];
    end
    for (genvar k = ENQ_W; k < BW; k++) begin : g_byp_pad
        assign byp_vld[k] = 1'b0;
        assign byp_dat[k] = '0;
    end
`endif

    always_comb begin
        deq_vld = '0;
        deq_dat = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            if (!q.flush) begin
`ifdef INSTQ_BYPASS_EN
                if (count_q == '0) begin
                    deq_vld[i] = byp_vld[i];
                    if (byp_vld[i]) deq_dat[i] = byp_dat[i];
                end else if (int'(count_q) > i) begin
                    deq_vld[i] = 1'b1;
                    deq_dat[i] = mem_q[wrap_add(head_q, i)];
                end
`else
                if (int'(count_q) > i) begin
                    deq_vld[i] = 1'b1;
                    deq_dat[i] = mem_q[wrap_add(head_q, i)];
                end
`endif
            end
        end
        n_deq = $countones(deq_vld & q.deq_ready);
    end

    always_comb begin
        n_enq   = enq_rdy ? $countones(q.enq_valid) : 0;
        head_d  = wrap_add(head_q, n_deq);
        tail_d  = wrap_add(tail_q, n_enq);
        count_d = CW'(int'(count_q) + n_enq - n_deq);
        for (int k = 0; k < ENQ_W; k++) begin
            wr_slot[k] = wrap_add(tail_q, k);
            wr_en[k]   = enq_rdy && q.enq_valid[k] && !rst && !q.flush;
`ifdef INSTQ_BYPASS_EN
            // Lanes consumed straight from the enqueue side never occupy a slot.
            if (count_q == '0 && k < n_deq) wr_en[k] = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < ENQ_W; k++) begin
            if (wr_en[k]) mem_q[wr_slot[k]] <= wr_dat[k];
        end
    end

    a_enq_prefix: assert property (@(posedge clk) disable iff (rst) is_prefix(4'(q.enq_valid)));
    a_deq_prefix: assert property (@(posedge clk) disable iff (rst) is_prefix(4'(q.deq_ready)));
endmodule

// File: doc/instq_mw.md
# instq_mw

Multi-lane instruction queue between fetch and decode; successor to the single-lane instruction queue. Accepts up to `ENQ_W` fetched instructions per cycle with their gshare prediction bits, and presents up to `DEQ_W` oldest entries to decode in show-ahead form. Supports arbitrary `DEPTH`, same-cycle enqueue and dequeue, and flush on branch redirect. Per-lane branch pre-decode for gshare is retained.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; integer ≥ `max(ENQ_W, DEQ_W)`; power of two not required.
- `ENQ_W`, 2, enqueue lanes, 1..4.
- `DEQ_W`, 2, dequeue lanes, 1..4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `flush`  in  1  branch redirect; empties the queue at the next edge.
- `enq_valid`  in  ENQ_W  lane valid; set lanes must form a prefix from lane 0.
- `enq_entry`  in  ENQ_W × if_id_stage_reg_t  pc, pc_next, out_inst per lane.
- `enq_pred`  in  ENQ_W  gshare prediction per lane; stored in the `.prediction` field.
- `enq_ready`  out  1  queue can accept `ENQ_W` entries this cycle.
- `br_is_br`  out  ENQ_W  lane opcode == op_b_br.
- `br_pc`  out  ENQ_W × 32  lane pc if the lane is a branch, else 0.
- `br_target`  out  ENQ_W × 32  pc + B-immediate (sign-extended, bit 0 = 0) if the lane is a branch, else 0.
- `deq_valid`  out  DEQ_W  lane i holds the i-th oldest entry.
- `deq_entry`  out  DEQ_W × if_id_stage_reg_t  entry data; all-zero when the lane is not valid.
- `deq_ready`  in  DEQ_W  consumer takes the lane; must be a prefix.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `empty`, `full`  out  1  count == 0 / count == DEPTH.

## Operation
- Circular buffer with `head`, `tail`, and `count` registers. Pointers advance modulo `DEPTH` with explicit wrap compare, not bit truncation.
- `enq_ready = (DEPTH - count) >= ENQ_W`. Only free slots at the current count are credited; a same-cycle dequeue gives no credit.
- Number enqueued: `n_enq = enq_ready ? popcount(enq_valid) : 0`.
  - Lane k writes slot `(tail+k) mod DEPTH`.
  - `tail += n_enq` (mod `DEPTH`).
- Dequeue output: `deq_valid[i] = (count > i) && !flush`; `deq_entry[i] = buf[(head+i) mod DEPTH]`. This is show-ahead: data is present without a request.
- Number dequeued: `n_deq = popcount(deq_valid & deq_ready)`.
  - `head += n_deq` (mod `DEPTH`).
  - Dequeued slots are not cleared.
- `count_next = count + n_enq − n_deq`. Simultaneous enqueue and dequeue is always legal.
- Flush, and reset identically:
  - Next edge: head = tail = count = 0.
  - Enqueue and dequeue in that cycle are discarded.
  - Buffer contents are left as-is; they are unobservable because valid is gated.
- Branch pre-decode (`br_*`) is purely combinational on `enq_entry`, independent of `enq_valid` and `enq_ready`.
- A non-prefix `enq_valid` or `deq_ready` is illegal. Flag it with an assertion; behaviour is undefined.

## Timing
- Enqueue-to-dequeue latency: 1 cycle. An entry written at edge N appears on `deq_valid` in cycle N+1.
- `enq_ready`, `count`, `empty`, `full` are combinational from registers only; there is no input-to-output path.
- `deq_valid` has a combinational path from `flush`.
- Reset values:
  - count = 0, `empty` = 1, `full` = 0.
  - `enq_ready` = 1.
  - `deq_valid` = 0, `deq_entry` = 0.
- Wrap-around: multi-lane writes and reads that straddle slot `DEPTH−1` → 0 must land in slots ..., `DEPTH−1`, 0, 1, ...

## Configuration
- `INSTQ_BYPASS_EN` defined, when `count == 0` and not flushing:
  - Dequeue lane i shows `enq_entry[i]` (prediction from `enq_pred[i]`), with `deq_valid[i] = enq_valid[i]`, in the same cycle.
  - Bypassed lanes that are taken are not written to the buffer.
  - Untaken lanes are enqueued normally.
  - Latency is 0 cycles for this case.
- Undefined: no bypass; latency is always 1 cycle.

## Test plan
- Reset, then idle: `empty`=1, `enq_ready`=1, `deq_valid`=0, `count`=0, all `deq_entry` zero.
- DEPTH=8, ENQ_W=DEQ_W=2, `deq_ready`=0. Enqueue pairs pc 0x100/0x104, 0x108/0x10C, … for 4 cycles.
  - Expect `count`=8, `full`=1, `enq_ready`=0.
  - A fifth pair is dropped.
  - Lanes show 0x100/0x104.
- From full, `deq_ready`=2'b11 and `enq_valid`=2'b11 in the same cycle: enqueue is refused (credit rule), `count`→6, lanes show 0x108/0x10C.
- DEPTH=5, ENQ_W=2. Steady enqueue 2 and dequeue 2 for 10 cycles: pc order is strictly sequential across the wrap, and `count` is constant.
- Queue holds 3 entries; assert `flush` together with `enq_valid`=11 and `deq_ready`=11.
  - `deq_valid`=0 that cycle.
  - Next cycle `count`=0, and none of the flush-cycle enqueues appear.
- Enqueue lane 1 inst 0xFE000EE3 (beq, imm −4) at pc 0x200: `br_is_br`=2'b10, `br_pc[1]`=0x200, `br_target[1]`=0x1FC. With `INSTQ_BYPASS_EN`, on an empty queue `deq_valid` is asserted in the same cycle.
